apb_master: RTL and testbench

APB requester that turns single-word read/write commands from an internal client into APB transfers, driving `apb_slave` (or any APB completer with the same port set) from the other end of the bus. It accepts one command at a time over a valid/ready handshake, sequences the bus through IDLE, SETUP and ACCESS, waits on `p_ready`, and returns read data or a timeout error on a one-cycle response strobe. It sits between a local controller or testbench sequencer and the APB slave fabric.

---
 rtl/apb_master.sv | 108 ++++++++++
 tb/tb_apb_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: accepts one read/write command at a time from a local client and
// runs it as a single APB transfer, returning read data or a timeout error.
module apb_master #(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    // Command handshake: a command transfers on any rising edge where
    // cmd_valid && cmd_ready; the client must hold its fields stable until then.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              p_sel,
    output logic              p_en,
    output logic              p_write,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] wdata,
    input  logic [DWIDTH-1:0] rdata,
    input  logic              p_ready,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TO_EN ? TIMEOUT - 1 : 0);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timed_out;

    assign cmd_ready = (state == IDLE);
    assign fsm_state = state;

    // Completion takes priority: p_ready on the last allowed edge is a success.
    assign timed_out = TO_EN && (wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            p_sel     <= 1'b0;
            p_en      <= 1'b0;
            p_write   <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    p_sel <= 1'b0;
                    p_en  <= 1'b0;
                    if (cmd_valid) begin
                        p_write <= cmd_write;
                        addr    <= cmd_addr;
                        wdata   <= cmd_wdata;
                        p_sel   <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    p_en     <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (p_ready) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= p_write ? '0 : rdata;
                        p_sel     <= 1'b0;
                        p_en      <= 1'b0;
                        state     <= IDLE;
                    end else if (timed_out) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        p_sel     <= 1'b0;
                        p_en      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    p_sel <= 1'b0;
                    p_en  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: table of single commands against a wait-state slave model,
// plus hand sequences for back-to-back, timeout, reset abort and ignored commands.
module tb_apb_master;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          p_sel, p_en, p_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          p_ready;
    logic [1:0]    fsm_state;

    always #5 clk = ~clk;

    apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .p_sel(p_sel), .p_en(p_en), .p_write(p_write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .p_ready(p_ready), .fsm_state(fsm_state)
    );

    // Slave model: registered p_ready after slave_waits extra ACCESS cycles; 255 = never ready.
    logic [DW-1:0] mem [256];
    int            slave_waits = 0;
    int            wcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_ready <= 1'b0;
            rdata   <= '0;
            wcnt    <= 0;
        end else if (p_sel && p_en) begin
            if (p_ready) begin
                p_ready <= 1'b0;
                wcnt    <= 0;
                if (p_write) mem[addr] <= wdata;
            end else if (slave_waits != 255 && wcnt == slave_waits) begin
                p_ready <= 1'b1;
                rdata   <= p_write ? '0 : mem[addr];
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            p_ready <= 1'b0;
            wcnt    <= 0;
        end
    end

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    // {err, rdata, due edge}
    logic [64:0]   exp_q[$];
    int            n_vec = 0;
    int            n_fail = 0;
    int            edge_cnt = 0;
    int            acc_edge = -10;
    logic [AW-1:0] cur_addr = '0;
    logic          cur_write = 1'b0;
    logic [DW-1:0] cur_wdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // One clock: push expectation on accept, advance, then check outputs on the falling edge.
    task automatic step(input logic [DW-1:0] e_rdata, input logic e_err, input int e_lat);
        logic [64:0] e;
        logic        exp_v;
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back({e_err, e_rdata, 32'(edge_cnt + 1 + e_lat)});
            acc_edge  = edge_cnt + 1;
            cur_addr  = cmd_addr;
            cur_write = cmd_write;
            cur_wdata = cmd_wdata;
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        if (edge_cnt == acc_edge) begin
            check("p_sel_setup", 64'(p_sel), 64'd1);
            check("p_en_setup", 64'(p_en), 64'd0);
        end
        if (edge_cnt == acc_edge + 1) check("p_en_access", 64'(p_en), 64'd1);
        if (p_sel) begin
            check("addr_stable", 64'(addr), 64'(cur_addr));
            check("p_write_stable", 64'(p_write), 64'(cur_write));
            if (cur_write) check("wdata_stable", 64'(wdata), 64'(cur_wdata));
        end
        exp_v = (exp_q.size() != 0) && (int'(exp_q[0][31:0]) == edge_cnt);
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            e = exp_q.pop_front();
            check("rsp_err", 64'(rsp_err), 64'(e[64]));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e[63:32]));
            check("p_sel_after_rsp", 64'(p_sel), 64'd0);
            check("p_en_after_rsp", 64'(p_en), 64'd0);
            check("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
        end else if (exp_q.size() != 0 && int'(exp_q[0][31:0]) < edge_cnt) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic run_cmd(input vec_t v);
        cmd_valid   = 1'b1;
        cmd_write   = v.write;
        cmd_addr    = v.addr;
        cmd_wdata   = v.wdata;
        slave_waits = v.waits;
        step(v.exp_rdata, v.exp_err, v.exp_lat);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step('0, 1'b0, 0);
    endtask

    vec_t vecs[10];
    vec_t rb[3];
    int   accs[3];
    int   na;
    logic acc_now;

    initial begin
        vecs[0] = '{1'b1, 8'h5A, 32'hDEADBEEF, 0,   32'h0,        1'b0, 3};
        vecs[1] = '{1'b0, 8'h5A, 32'h0,        0,   32'hDEADBEEF, 1'b0, 3};
        vecs[2] = '{1'b1, 8'h10, 32'h12345678, 1,   32'h0,        1'b0, 4};
        vecs[3] = '{1'b0, 8'h10, 32'h0,        4,   32'h12345678, 1'b0, 7};
        vecs[4] = '{1'b1, 8'h33, 32'hA5A50F0F, 13,  32'h0,        1'b0, 16};
        vecs[5] = '{1'b0, 8'h33, 32'h0,        14,  32'hA5A50F0F, 1'b0, 17};
        vecs[6] = '{1'b0, 8'h10, 32'h0,        255, 32'h0,        1'b1, 17};
        vecs[7] = '{1'b1, 8'h20, 32'hCAFE0020, 0,   32'h0,        1'b0, 3};
        vecs[8] = '{1'b1, 8'h5A, 32'h0BAD0BAD, 255, 32'h0,        1'b1, 17};
        vecs[9] = '{1'b0, 8'h5A, 32'h0,        2,   32'hDEADBEEF, 1'b0, 5};
        for (int i = 0; i < 3; i++)
            rb[i] = '{1'b0, 8'(i + 1), 32'h0, 0, 32'h11110000 + 32'(i + 1), 1'b0, 3};

        // Reset values while reset is held
        #1 rst = 1'b0;
        #1;
        check("rst_p_sel", 64'(p_sel), 64'd0);
        check("rst_p_en", 64'(p_en), 64'd0);
        check("rst_p_write", 64'(p_write), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step('0, 1'b0, 0);

        for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

        // Back-to-back writes with cmd_valid held
        na = 0;
        slave_waits = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h01;
        cmd_wdata = 32'h11110001;
        for (int i = 0; i < 40 && (na < 3 || exp_q.size() != 0); i++) begin
            acc_now = cmd_valid && cmd_ready;
            step('0, 1'b0, 3);
            if (acc_now) begin
                accs[na] = acc_edge;
                na++;
                if (na < 3) begin
                    cmd_addr  = 8'(na + 1);
                    cmd_wdata = 32'h11110000 + 32'(na + 1);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        check("b2b_accepts", 64'(na), 64'd3);
        if (na == 3) begin
            check("b2b_gap1", 64'(accs[1] - accs[0]), 64'd4);
            check("b2b_gap2", 64'(accs[2] - accs[1]), 64'd4);
        end
        for (int i = 0; i < 3; i++) run_cmd(rb[i]);

        // Reset during ACCESS of a write: silent abort
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h40;
        cmd_wdata = 32'h40404040;
        slave_waits = 3;
        step('0, 1'b0, 6);
        cmd_valid = 1'b0;
        step('0, 1'b0, 0);
        rst = 1'b0;
        #1;
        check("abort_p_sel", 64'(p_sel), 64'd0);
        check("abort_p_en", 64'(p_en), 64'd0);
        check("abort_p_write", 64'(p_write), 64'd0);
        check("abort_addr", 64'(addr), 64'd0);
        check("abort_wdata", 64'(wdata), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_q.delete();
        step('0, 1'b0, 0);
        step('0, 1'b0, 0);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step('0, 1'b0, 0);
        run_cmd(vecs[1]);

        // Command pulsed during SETUP/ACCESS is ignored
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        slave_waits = 2;
        step(32'hCAFE0020, 1'b0, 5);
        cmd_write = 1'b1;
        cmd_addr  = 8'hFF;
        cmd_wdata = 32'hFFFFFFFF;
        step('0, 1'b0, 0);
        step('0, 1'b0, 0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step('0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            step('0, 1'b0, 0);
            check("ignored_no_sel", 64'(p_sel), 64'd0);
        end
        check("idle_addr_kept", 64'(addr), 64'h20);
        check("idle_p_write_kept", 64'(p_write), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_fail);
        $fatal(1);
    end
endmodule
